// File: rtl/sdram_req_seq_pkg.sv
// rtl/sdram_req_seq_pkg.sv - shared sizes, command codes and state encoding for sdram_req_seq
package sdram_req_seq_pkg;

  localparam int padd_size = 24;
  localparam int data_size = 32;
  localparam int dqm_size  = 4;
  localparam int cmd_size  = 3;
  localparam int tmr_w     = 16;

  typedef enum logic [cmd_size-1:0] {
    CMD_NOP       = 3'b000,
    CMD_READA     = 3'b001,
    CMD_WRITEA    = 3'b010,
    CMD_REFRESH   = 3'b011,
    CMD_PRECHARGE = 3'b100,
    CMD_LOAD_MODE = 3'b101
  } cmd_t;

  typedef enum logic [3:0] {
    S_WAIT, S_PRE, S_REF1, S_REF2, S_LMR,
    S_IDLE, S_ISSUE, S_RDWAIT, S_WRHOLD, S_DONE
  } state_t;

  // Timer load value for an N-cycle interval: done rises in the Nth cycle after loading.
  function automatic logic [tmr_w-1:0] tmr_count(input int cycles);
    if (cycles <= 1) return '0;
    if (cycles > (1 << tmr_w)) return '1;
    return tmr_w'(cycles - 1);
  endfunction

endpackage

// File: rtl/seq_timer.sv
// rtl/seq_timer.sv - loadable down-counter that stops at zero and flags done
module seq_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/sdram_req_seq.sv
// rtl/sdram_req_seq.sv - SDRAM init sequencer and single-access host request bridge
module sdram_req_seq
  import sdram_req_seq_pkg::*;
#(
  parameter int                PADD_W    = padd_size,
  parameter int                DATA_W    = data_size,
  parameter int                DQM_W     = dqm_size,
  parameter int                CMD_W     = cmd_size,
  parameter int                INIT_WAIT = 100,
  parameter int                RD_LAT    = 5,
  parameter int                WR_HOLD   = 3,
  parameter int                TIMEOUT   = 255,
  parameter logic [PADD_W-1:0] MODE_WORD = 24'h000022
) (
  input  logic              clk0,
  input  logic              reset,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [PADD_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic [DQM_W-1:0]  host_be,
  output logic              host_rdy,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              init_done,
  output logic              err,
  output logic [PADD_W-1:0] paddr,
  output logic [CMD_W-1:0]  cmd,
  output logic [DQM_W-1:0]  dm,
  output logic [DATA_W-1:0] datain,
  input  logic              cmdack,
  input  logic [DATA_W-1:0] dataout
);

  localparam logic [tmr_w-1:0]  WAIT_LD = tmr_count(INIT_WAIT);
  localparam logic [tmr_w-1:0]  RD_LD   = tmr_count(RD_LAT);
  localparam logic [tmr_w-1:0]  WR_LD   = tmr_count(WR_HOLD);
  localparam logic [tmr_w-1:0]  TMO_LD  = tmr_count(TIMEOUT);
  localparam logic [PADD_W-1:0] PRE_ALL = PADD_W'(11'h400);

  state_t            state;
  logic              cap_we;
  logic              tmr_load;
  logic [tmr_w-1:0]  tmr_val;
  logic              tmr_done;

  seq_timer #(.W(tmr_w)) u_timer (
    .clk      (clk0),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Reload the timer on every state exit with the interval the next state needs.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = TMO_LD;
    case (state)
      S_WAIT:                tmr_load = tmr_done;
      S_PRE:                 tmr_load = (cmd == CMD_NOP) || cmdack || tmr_done;
      S_REF1, S_REF2, S_LMR: tmr_load = cmdack || tmr_done;
      S_IDLE:                tmr_load = host_req;
      S_ISSUE: begin
        tmr_load = cmdack || tmr_done;
        if (cmdack) tmr_val = cap_we ? WR_LD : RD_LD;
      end
      default: ;
    endcase
    if (reset) begin
      tmr_load = 1'b1;
      tmr_val  = WAIT_LD;
    end
  end

  always_ff @(posedge clk0) begin
    if (reset) begin
      state      <= S_WAIT;
      cmd        <= CMD_NOP;
      paddr      <= '0;
      dm         <= '0;
      datain     <= '0;
      host_rdy   <= 1'b0;
      host_ack   <= 1'b0;
      host_rdata <= '0;
      init_done  <= 1'b0;
      err        <= 1'b0;
      cap_we     <= 1'b0;
    end else begin
      host_ack <= 1'b0;
      case (state)
        S_WAIT: if (tmr_done) begin
          state <= S_PRE;
          cmd   <= CMD_PRECHARGE;
          paddr <= PRE_ALL;
        end
        S_PRE, S_REF1, S_REF2, S_LMR: begin
          // After an init timeout S_PRE is entered with NOP for one cycle before re-issuing.
          if (state == S_PRE && cmd == CMD_NOP) begin
            cmd <= CMD_PRECHARGE;
          end else if (cmdack) begin
            case (state)
              S_PRE: begin
                state <= S_REF1;
                cmd   <= CMD_REFRESH;
                paddr <= '0;
              end
              S_REF1: state <= S_REF2;
              S_REF2: begin
                state <= S_LMR;
                cmd   <= CMD_LOAD_MODE;
                paddr <= MODE_WORD;
              end
              default: begin
                state     <= S_IDLE;
                cmd       <= CMD_NOP;
                paddr     <= '0;
                init_done <= 1'b1;
                host_rdy  <= 1'b1;
              end
            endcase
          end else if (tmr_done) begin
            err   <= 1'b1;
            cmd   <= CMD_NOP;
            state <= S_PRE;
            paddr <= PRE_ALL;
          end
        end
        S_IDLE: if (host_req) begin
          state    <= S_ISSUE;
          host_rdy <= 1'b0;
          cap_we   <= host_we;
          paddr    <= host_addr;
          cmd      <= host_we ? CMD_WRITEA : CMD_READA;
          datain   <= host_we ? host_wdata : '0;
          dm       <= host_we ? ~host_be : '0;
        end
        S_ISSUE: begin
          if (cmdack) begin
            cmd   <= CMD_NOP;
            state <= cap_we ? S_WRHOLD : S_RDWAIT;
          end else if (tmr_done) begin
            err      <= 1'b1;
            cmd      <= CMD_NOP;
            dm       <= '0;
            state    <= S_DONE;
            host_ack <= 1'b1;
          end
        end
        S_RDWAIT: if (tmr_done) begin
          host_rdata <= dataout;
          state      <= S_DONE;
          host_ack   <= 1'b1;
        end
        S_WRHOLD: if (tmr_done) begin
          dm       <= '0;
          state    <= S_DONE;
          host_ack <= 1'b1;
        end
        S_DONE: begin
          state    <= S_IDLE;
          host_rdy <= 1'b1;
        end
        default: state <= S_WAIT;
      endcase
    end
  end

endmodule
